spi_mem_ctrl: RTL and testbench

Command controller and port arbiter between the SPI slave's 10-bit receive stream and a single-port synchronous RAM. It decodes rx_data commands (set write address, write data, set read address, read data) and returns read bytes to the slave via tx_data/tx_valid. It also shares the one RAM port with a local host requester using two-way round-robin arbitration.

---
 rtl/spi_mem_ctrl_if.sv | 40 ++++
 rtl/spi_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_ctrl_if.sv
// Bus bundle for spi_mem_ctrl: SPI slave word stream, host requester and
// single-port RAM. slave = controller side, master = environment side.
interface spi_mem_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // SPI slave side: [ADDR_W+1:ADDR_W] command, [ADDR_W-1:0] payload
  logic [ADDR_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  // host requester
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  // RAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              spi_overrun;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output tx_data, tx_valid, host_gnt, host_rvalid, host_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, spi_overrun
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  tx_data, tx_valid, host_gnt, host_rvalid, host_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, spi_overrun
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI command decoder plus two-way round-robin arbiter in front of a single
// port synchronous RAM. SPI data accesses go through a one-deep pending slot;
// the host shares the port with a combinational grant.
module spi_mem_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PEND    = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WR    = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RD    = 2'b11;

  state_t            r_state;
  logic              r_rx_valid_q;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_pend_we;
  logic [DATA_W-1:0] r_pend_wdata;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_overrun;
  logic              r_rr_spi;      // 1: SPI wins the next tie
  logic              r_host_rd_q;   // host read issued on the last edge
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_host_rdata;

  logic              w_capture;
  logic [1:0]        w_cmd;
  logic              w_spi_req;
  logic              w_gnt_spi;
  logic              w_gnt_host;

  // Rising edge of rx_valid only; a held level issues one command.
  assign w_capture  = bus.rx_valid & ~r_rx_valid_q;
  assign w_cmd      = bus.rx_data[ADDR_W+1:ADDR_W];

  assign w_spi_req  = (r_state == S_PEND);
  assign w_gnt_spi  = w_spi_req & (~bus.host_req | r_rr_spi);
  assign w_gnt_host = bus.host_req & ~w_gnt_spi;

  // RAM port is driven only in a grant cycle, by the winner.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_gnt_spi) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = r_pend_we;
      bus.mem_addr  = r_pend_we ? r_wr_addr : r_rd_addr;
      bus.mem_wdata = r_pend_we ? r_pend_wdata : '0;
    end else if (w_gnt_host) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  // SPI command decode, pending access and read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rx_valid_q <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_we    <= 1'b0;
      r_pend_wdata <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_valid_q <= bus.rx_valid;
      if (w_capture) r_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            case (w_cmd)
              CMD_WADDR: r_wr_addr <= bus.rx_data[ADDR_W-1:0];
              CMD_RADDR: r_rd_addr <= bus.rx_data[ADDR_W-1:0];
              CMD_WR: begin
                r_pend_we    <= 1'b1;
                r_pend_wdata <= bus.rx_data[DATA_W-1:0];
                r_state      <= S_PEND;
              end
              default: begin
                r_pend_we <= 1'b0;
                r_state   <= S_PEND;
              end
            endcase
          end
        end
        S_PEND: begin
          // a new command while one is in flight is dropped
          if (w_capture) r_overrun <= 1'b1;
          if (w_gnt_spi) begin
            if (AUTO_INC) begin
              if (r_pend_we) r_wr_addr <= r_wr_addr + ADDR_W'(1);
              else           r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            r_state <= r_pend_we ? S_IDLE : S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (w_capture) r_overrun <= 1'b1;
          // completion wins over the clear from a dropped capture
          r_tx_data  <= bus.mem_rdata;
          r_tx_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Round-robin pointer: after a grant the other requester has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_rr_spi <= 1'b1;
    else if (w_gnt_spi)  r_rr_spi <= 1'b0;
    else if (w_gnt_host) r_rr_spi <= 1'b1;
  end

  // Host read return: RAM data lands the cycle after the access edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_host_rd_q   <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_host_rd_q   <= w_gnt_host & ~bus.host_we;
      r_host_rvalid <= r_host_rd_q;
      if (r_host_rd_q) r_host_rdata <= bus.mem_rdata;
    end
  end

  assign bus.host_gnt    = w_gnt_host;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.spi_overrun = r_overrun;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: behavioural RAM, directed command table,
// hand-written arbitration/overrun/reset sequences and a randomized phase
// with concurrent SPI and host traffic checked against a reference model.
module tb_spi_mem_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  spi_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AUTO_INC(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // synchronous single-port RAM
  logic [7:0] ram [256];
  logic [7:0] ram_q;
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  int mon_en = 0;
  int host_gnts = 0;
  always @(posedge clk) if (mon_en != 0 && bus.host_gnt) host_gnts <= host_gnts + 1;

  int n_tests = 0;
  int n_fail = 0;

  // reference model: memory contents and the two SPI address registers
  logic [7:0] ref_mem [256];
  logic [7:0] m_wr, m_rd;

  typedef struct {
    logic [9:0] rx;
    bit         is_rd;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [9:0] w, output logic [7:0] exp);
    exp = 8'h00;
    case (w[9:8])
      2'b00: m_wr = w[7:0];
      2'b10: m_rd = w[7:0];
      2'b01: begin ref_mem[m_wr] = w[7:0]; m_wr = m_wr + 8'd1; end
      default: begin exp = ref_mem[m_rd]; m_rd = m_rd + 8'd1; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_wr = 8'h00;
    m_rd = 8'h00;
  endtask

  // issue one SPI word; for reads wait (bounded) for tx_valid
  task automatic spi_op(input logic [9:0] w, input int hold,
                        output logic [7:0] got, output bit seen, output logic [7:0] mexp);
    model_apply(w, mexp);
    got = 8'h00;
    seen = 1'b0;
    @(negedge clk);
    bus.rx_data = w;
    bus.rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.rx_valid = 1'b0;
    if (w[9:8] == 2'b11) begin
      for (int t = 0; t < 12 && !seen; t++) begin
        if (bus.tx_valid) seen = 1'b1;
        else @(negedge clk);
      end
      got = bus.tx_data;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic spi_cmd(input logic [9:0] w);
    logic [7:0] g, e;
    bit s;
    spi_op(w, 1, g, s, e);
  endtask

  // SPI read with cycle-exact checks; SPI must win the port at once
  task automatic spi_read_timed(input string name, input bit hreq);
    logic [7:0] a, exp;
    a = m_rd;
    model_apply(10'h300, exp);
    @(negedge clk);
    bus.rx_data = 10'h300;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
    check({name, " spi grant"}, {bus.mem_en, bus.mem_we, bus.host_gnt, bus.mem_addr},
          {1'b1, 1'b0, 1'b0, a});
    @(negedge clk);
    check({name, " tx_valid early"}, bus.tx_valid, 0);
    check({name, " host gnt after spi"}, bus.host_gnt, hreq);
    @(negedge clk);
    check({name, " tx_valid"}, bus.tx_valid, 1);
    check({name, " tx_data"}, bus.tx_data, exp);
    repeat (2) @(negedge clk);
  endtask

  task automatic host_access(input bit we, input logic [7:0] addr, input logic [7:0] data,
                             input string name);
    bit got;
    logic [7:0] exp;
    got = 1'b0;
    exp = 8'h00;
    @(negedge clk);
    bus.host_req = 1'b1;
    bus.host_we = we;
    bus.host_addr = addr;
    bus.host_wdata = data;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (bus.host_gnt) got = 1'b1;
      else @(negedge clk);
    end
    check({name, " granted"}, got, 1);
    if (got) begin
      if (we) ref_mem[addr] = data;
      else exp = ref_mem[addr];
    end
    @(negedge clk);
    bus.host_req = 1'b0;
    if (got && !we) begin
      check({name, " rvalid early"}, bus.host_rvalid, 0);
      @(negedge clk);
      check({name, " rvalid"}, bus.host_rvalid, 1);
      check({name, " rdata"}, bus.host_rdata, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: sim did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    logic [7:0] g, e, old, dat;
    bit s;
    int cnt0;

    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    m_wr = 8'h00; m_rd = 8'h00;

    // reset state
    @(negedge clk);
    check("rst tx_valid", bus.tx_valid, 0);
    check("rst tx_data", bus.tx_data, 0);
    check("rst overrun", bus.spi_overrun, 0);
    check("rst host_rvalid", bus.host_rvalid, 0);
    check("rst host_rdata", bus.host_rdata, 0);
    check("rst mem_en", bus.mem_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first tie after reset goes to SPI, then host
    @(negedge clk);
    bus.rx_data = 10'h300; bus.rx_valid = 1'b1;
    model_apply(10'h300, e);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'hF0; bus.host_wdata = 8'h3C;
    #1;
    check("tie spi first", {bus.mem_en, bus.mem_we, bus.host_gnt, bus.mem_addr}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    check("tie host next", {bus.host_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 8'hF0, 8'h3C});
    ref_mem[8'hF0] = 8'h3C;
    bus.host_req = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // directed command table
    tbl[0]  = '{10'h000, 1'b0, 8'h00};
    tbl[1]  = '{10'h1A5, 1'b0, 8'h00};
    tbl[2]  = '{10'h300, 1'b1, 8'hA5};  // read address defaults to 0
    tbl[3]  = '{10'h200, 1'b0, 8'h00};
    tbl[4]  = '{10'h300, 1'b1, 8'hA5};
    tbl[5]  = '{10'h0FF, 1'b0, 8'h00};
    tbl[6]  = '{10'h111, 1'b0, 8'h00};
    tbl[7]  = '{10'h122, 1'b0, 8'h00};  // write address wrapped to 0
    tbl[8]  = '{10'h2FF, 1'b0, 8'h00};
    tbl[9]  = '{10'h300, 1'b1, 8'h11};
    tbl[10] = '{10'h300, 1'b1, 8'h22};  // read address wrapped to 0
    foreach (tbl[i]) begin
      spi_op(tbl[i].rx, 1, g, s, e);
      if (tbl[i].is_rd) begin
        check($sformatf("tbl%0d tx_valid", i), s, 1);
        check($sformatf("tbl%0d tx_data", i), g, tbl[i].exp);
      end
    end
    check("wrap ram[FF]", ram[8'hFF], 8'h11);
    check("wrap ram[00]", ram[8'h00], 8'h22);

    // held rx_valid: one write, one increment
    cnt0 = wr_cnt;
    spi_op(10'h1A5, 20, g, s, e);
    check("held write count", wr_cnt - cnt0, 1);
    spi_cmd(10'h1B6);
    check("held ram[01]", ram[8'h01], 8'hA5);
    check("held ram[02]", ram[8'h02], 8'hB6);

    // contention: host writes continuously while SPI reads
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'hF0; bus.host_wdata = 8'h3C;
    ref_mem[8'hF0] = 8'h3C;
    spi_cmd(10'h200);
    host_gnts = 0; mon_en = 1;
    for (int i = 0; i < 3; i++) spi_read_timed($sformatf("cont%0d", i), 1'b1);
    mon_en = 0;
    bus.host_req = 1'b0;
    check("cont host not starved", host_gnts >= 9, 1);

    // fill RAM: low half through SPI, high half through host
    spi_cmd(10'h000);
    for (int i = 0; i < 128; i++) spi_cmd({2'b01, 8'($urandom_range(0, 255))});
    for (int i = 128; i < 256; i++) host_access(1'b1, 8'(i), 8'($urandom_range(0, 255)), "fill");
    check("fill ram[7F]", ram[8'h7F], ref_mem[8'h7F]);

    // overrun: second command while SPI waits behind the host
    spi_cmd(10'h010);
    spi_cmd(10'h155);
    spi_cmd(10'h210);
    old = ref_mem[m_wr];
    @(negedge clk);
    bus.rx_data = 10'h300; bus.rx_valid = 1'b1;
    model_apply(10'h300, e);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'hF0; bus.host_wdata = 8'h3C;
    ref_mem[8'hF0] = 8'h3C;
    #1;
    check("ovr host wins tie", bus.host_gnt, 1);
    @(negedge clk);
    bus.rx_data = {2'b01, ~old}; bus.rx_valid = 1'b1;
    #1;
    check("ovr spi next", {bus.mem_en, bus.host_gnt}, {1'b1, 1'b0});
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check("ovr sticky set", bus.spi_overrun, 1);
    @(negedge clk);
    check("ovr first tx_valid", bus.tx_valid, 1);
    check("ovr first tx_data", bus.tx_data, e);
    bus.host_req = 1'b0;
    repeat (4) @(negedge clk);
    check("ovr dropped write", ram[m_wr], old);
    check("ovr still set", bus.spi_overrun, 1);

    // reset during RD_WAIT
    spi_cmd(10'h205);
    @(negedge clk);
    bus.rx_data = 10'h300; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rdw rst tx_valid", bus.tx_valid, 0);
    check("rdw rst mem_en", bus.mem_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 8'h00; m_rd = 8'h00;
    check("rdw after tx_valid", bus.tx_valid, 0);
    check("rdw after tx_data", bus.tx_data, 0);
    check("rdw after overrun", bus.spi_overrun, 0);
    spi_read_timed("rdw next read", 1'b0);

    // randomized concurrent traffic; SPI owns 00-7F, host owns 80-FF
    fork
      begin
        logic [9:0] w;
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0: w = {2'b00, 1'b0, 7'($urandom_range(0, 127))};
            1: w = {2'b10, 1'b0, 7'($urandom_range(0, 127))};
            2: begin
              if (m_wr[7]) spi_cmd({2'b00, 1'b0, 7'($urandom_range(0, 127))});
              w = {2'b01, 8'($urandom_range(0, 255))};
            end
            default: begin
              if (m_rd[7]) spi_cmd({2'b10, 1'b0, 7'($urandom_range(0, 127))});
              w = 10'h300;
            end
          endcase
          spi_op(w, $urandom_range(1, 3), g, s, e);
          if (w[9:8] == 2'b11) begin
            check($sformatf("rnd spi%0d tx_valid", i), s, 1);
            check($sformatf("rnd spi%0d tx_data", i), g, e);
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          dat = 8'($urandom_range(0, 255));
          host_access(1'($urandom_range(0, 1)), {1'b1, 7'($urandom_range(0, 127))}, dat,
                      $sformatf("rnd host%0d", i));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
